// File: rtl/mmio_hub_pkg.sv
// Shared definitions for mmio_hub: address regions, IO register offsets and
// KB_STATUS bit layout.
package mmio_hub_pkg;

  typedef enum logic [1:0] {
    REGION_DMEM = 2'd0,
    REGION_SCR  = 2'd1,
    REGION_IO   = 2'd2,
    REGION_NONE = 2'd3
  } region_e;

  localparam logic [2:0] IO_KB_DATA   = 3'd0;
  localparam logic [2:0] IO_KB_STATUS = 3'd1;
  localparam logic [2:0] IO_SEG       = 3'd2;
  localparam logic [2:0] IO_TIMER     = 3'd3;

  localparam int KB_ST_EMPTY   = 0;
  localparam int KB_ST_FULL    = 1;
  localparam int KB_ST_OVF     = 2;
  localparam int KB_ST_CNT_LSB = 8;

  function automatic logic [31:0] kb_status_word(input logic [7:0] count,
                                                 input logic       ovf,
                                                 input logic       full,
                                                 input logic       empty);
    logic [31:0] w;
    w                      = 32'd0;
    w[KB_ST_CNT_LSB +: 8]  = count;
    w[KB_ST_OVF]           = ovf;
    w[KB_ST_FULL]          = full;
    w[KB_ST_EMPTY]         = empty;
    return w;
  endfunction

endpackage

// File: rtl/mmio_kb_fifo.sv
// Keyboard character FIFO; power-of-2 depth, a pop and a push may complete in
// the same cycle even when full.
module mmio_kb_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty     = (count_r == '0);
  assign full      = (count_r == (PW+1)'(DEPTH));
  assign count     = count_r;
  assign data      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  // A full FIFO accepts a push only when the same edge frees a slot.
  assign do_push_s = push & (~full | do_pop_s);

  // Character storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s && !reset) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1'b1);
        2'b01:   count_r <= count_r - (PW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// CPU memory-mapped hub: data memory, character screen memory and IO registers
// (keyboard FIFO, 7-segment value, cycle timer). Macro: MMIO_HUB_TIMER_EN builds
// the TIMER counter.
module mmio_hub
  import mmio_hub_pkg::*;
#(
  parameter int DMEM_WORDS = 1024,
  parameter int SCR_WORDS  = 1200,
  parameter int CHAR_W     = 4,
  parameter int KB_DEPTH   = 8,
  parameter     DMEM_INIT  = "dmem.txt",
  parameter     SCR_INIT   = "screenmem_init.txt"
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_wr,
  input  logic                         mem_rd,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_writedata,
  output logic [31:0]                  mem_readdata,
  input  logic [7:0]                   kb_char,
  input  logic                         kb_valid,
  input  logic [$clog2(SCR_WORDS)-1:0] scr_rd_addr,
  output logic [CHAR_W-1:0]            scr_rd_char,
  output logic [31:0]                  seg_value
);

  localparam int          DAW       = $clog2(DMEM_WORDS);
  localparam int          SAW       = $clog2(SCR_WORDS);
  localparam int          CW        = $clog2(KB_DEPTH) + 1;
  localparam logic [13:0] SCR_LIMIT = 14'(SCR_WORDS);

  logic [31:0]       dmem_r [DMEM_WORDS];
  logic [CHAR_W-1:0] scr_r  [SCR_WORDS];
  logic [31:0]       seg_r;
  logic              ovf_r;
  logic [31:0]       timer_s;

  region_e           region_s;
  logic [13:0]       word_idx_s;
  logic [2:0]        io_off_s;
  logic [DAW-1:0]    dmem_idx_s;
  logic [SAW-1:0]    scr_idx_s;
  logic              scr_in_range_s;
  logic              wr_en_s;
  logic              io_we_s;
  logic              kb_pop_s;
  logic              kb_push_s;
  logic [7:0]        kb_data_s;
  logic [CW-1:0]     kb_count_s;
  logic              kb_full_s;
  logic              kb_empty_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  assign region_s       = region_e'(mem_addr[17:16]);
  assign word_idx_s     = mem_addr[15:2];
  assign io_off_s       = mem_addr[4:2];
  assign dmem_idx_s     = word_idx_s[DAW-1:0];
  assign scr_idx_s      = word_idx_s[SAW-1:0];
  assign scr_in_range_s = (word_idx_s < SCR_LIMIT);
  assign unused_s       = ^{mem_addr[31:18], mem_addr[1:0]};

  assign wr_en_s   = mem_wr & ~reset;
  assign io_we_s   = wr_en_s & (region_s == REGION_IO);
  assign kb_pop_s  = mem_rd & ~reset & (region_s == REGION_IO) & (io_off_s == IO_KB_DATA);
  assign kb_push_s = kb_valid & ~reset;

  mmio_kb_fifo #(
    .DEPTH (KB_DEPTH),
    .WIDTH (8)
  ) u_kb_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (kb_push_s),
    .pop       (kb_pop_s),
    .push_data (kb_char),
    .data      (kb_data_s),
    .count     (kb_count_s),
    .full      (kb_full_s),
    .empty     (kb_empty_s)
  );

  // Memory array writes; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_en_s && region_s == REGION_DMEM) begin
      dmem_r[dmem_idx_s] <= mem_writedata;
    end
    if (wr_en_s && region_s == REGION_SCR && scr_in_range_s) begin
      scr_r[scr_idx_s] <= mem_writedata[CHAR_W-1:0];
    end
  end

  // SEG register and sticky keyboard overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r <= 32'd0;
      ovf_r <= 1'b0;
    end else begin
      if (io_we_s && io_off_s == IO_SEG) seg_r <= mem_writedata;
      // A dropped character wins over a same-cycle clear so it is never lost.
      if (kb_push_s && kb_full_s && !kb_pop_s) begin
        ovf_r <= 1'b1;
      end else if (io_we_s && io_off_s == IO_KB_STATUS) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign seg_value = seg_r;

`ifdef MMIO_HUB_TIMER_EN
  logic [31:0] timer_r;

  // Free-running cycle counter, loadable from the CPU.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= 32'd0;
    end else if (io_we_s && io_off_s == IO_TIMER) begin
      timer_r <= mem_writedata;
    end else begin
      timer_r <= timer_r + 32'd1;
    end
  end

  assign timer_s = timer_r;
`else
  assign timer_s = 32'd0;
`endif

  // Display port reads asynchronously; indices past the screen read as blank.
  assign scr_rd_char = ({{(14-SAW){1'b0}}, scr_rd_addr} < SCR_LIMIT) ? scr_r[scr_rd_addr]
                                                                      : {CHAR_W{1'b0}};

  // Combinational CPU read mux across all regions.
  always_comb begin
    rdata_s = 32'd0;
    case (region_s)
      REGION_DMEM: rdata_s = dmem_r[dmem_idx_s];
      REGION_SCR: begin
        if (scr_in_range_s) begin
          rdata_s = {{(32-CHAR_W){1'b0}}, scr_r[scr_idx_s]};
        end else begin
          rdata_s = 32'd0;
        end
      end
      REGION_IO: begin
        case (io_off_s)
          IO_KB_DATA: begin
            if (kb_empty_s) begin
              rdata_s = 32'd0;
            end else begin
              rdata_s = {24'd0, kb_data_s};
            end
          end
          IO_KB_STATUS: rdata_s = kb_status_word(8'(kb_count_s), ovf_r, kb_full_s, kb_empty_s);
          IO_SEG:       rdata_s = seg_r;
          IO_TIMER:     rdata_s = timer_s;
          default:      rdata_s = 32'd0;
        endcase
      end
      default: rdata_s = 32'd0;
    endcase
  end

  assign mem_readdata = rdata_s;

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub: directed scenarios with a scoreboard of
// expected read/port values compared as the DUT produces them.
module tb_mmio_hub;

  localparam logic [31:0] A_KB_DATA   = 32'h0002_0000;
  localparam logic [31:0] A_KB_STATUS = 32'h0002_0004;
  localparam logic [31:0] A_SEG       = 32'h0002_0008;
  localparam logic [31:0] A_TIMER     = 32'h0002_000C;
  localparam logic [31:0] A_IO_RSVD   = 32'h0002_0010;
  localparam logic [31:0] A_UNMAPPED  = 32'h0003_0000;
  localparam logic [31:0] A_SCR       = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_writedata = 32'd0;
  logic [31:0] mem_readdata;
  logic [7:0]  kb_char = 8'd0;
  logic        kb_valid = 1'b0;
  logic [10:0] scr_rd_addr = 11'd0;
  logic [3:0]  scr_rd_char;
  logic [31:0] seg_value;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string       tag_q[$];

  mmio_hub dut (
    .clk           (clk),
    .reset         (reset),
    .mem_wr        (mem_wr),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .kb_char       (kb_char),
    .kb_valid      (kb_valid),
    .scr_rd_addr   (scr_rd_addr),
    .scr_rd_char   (scr_rd_char),
    .seg_value     (seg_value)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  // One bus/keyboard cycle: drive at negedge, sample read data, commit at posedge.
  task automatic cyc(input logic [31:0] addr, input logic rd, input logic wr,
                     input logic [31:0] wdata, input logic kv, input logic [7:0] kc,
                     output logic [31:0] rdata);
    @(negedge clk);
    mem_addr = addr; mem_rd = rd; mem_wr = wr; mem_writedata = wdata;
    kb_valid = kv; kb_char = kc;
    #1 rdata = mem_readdata;
    @(posedge clk);
    #1;
    mem_rd = 1'b0; mem_wr = 1'b0; kb_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic pop);
    logic [31:0] v;
    cyc(addr, pop, 1'b0, 32'd0, 1'b0, 8'd0, v);
    obs_q.push_back(v);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] v;
    cyc(addr, 1'b0, 1'b1, data, 1'b0, 8'd0, v);
  endtask

  task automatic kb_push(input logic [7:0] c);
    logic [31:0] v;
    cyc(A_UNMAPPED, 1'b0, 1'b0, 32'd0, 1'b1, c, v);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (2) @(posedge clk);
    cyc(A_SEG, 1'b0, 1'b1, 32'h0000_00AA, 1'b1, 8'h55, v);
    @(negedge clk);
    reset = 1'b0;
    expect_val("rst_status", 32'h0000_0001); rd(A_KB_STATUS, 1'b0);
    expect_val("rst_seg_rd", 32'd0);         rd(A_SEG, 1'b0);
    expect_val("rst_seg_port", 32'd0);       obs_q.push_back(seg_value);
    while (exp_q.size() > 0) begin
      logic [31:0] e, o; string t;
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_kb_basic();
    kb_push(8'h41); kb_push(8'h42); kb_push(8'h43);
    expect_val("kb3_status", 32'h0000_0300); rd(A_KB_STATUS, 1'b0);
    expect_val("kb_pop0", 32'h41); rd(A_KB_DATA, 1'b1);
    expect_val("kb_pop1", 32'h42); rd(A_KB_DATA, 1'b1);
    expect_val("kb_pop2", 32'h43); rd(A_KB_DATA, 1'b1);
    expect_val("kb_pop_empty", 32'h0); rd(A_KB_DATA, 1'b1);
    expect_val("kb_empty_status", 32'h0000_0001); rd(A_KB_STATUS, 1'b0);
    while (exp_q.size() > 0) begin
      logic [31:0] e, o; string t;
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_kb_overflow();
    for (int i = 0; i < 9; i++) kb_push(8'h50 + 8'(i));
    expect_val("ovf_status", 32'h0000_0806); rd(A_KB_STATUS, 1'b0);
    wr(A_KB_STATUS, 32'h0000_0000);
    expect_val("ovf_cleared", 32'h0000_0802); rd(A_KB_STATUS, 1'b0);
    for (int i = 0; i < 8; i++) begin
      expect_val($sformatf("ovf_drain%0d", i), 32'h50 + 32'(i));
      rd(A_KB_DATA, 1'b1);
    end
    expect_val("ovf_final_status", 32'h0000_0001); rd(A_KB_STATUS, 1'b0);
    while (exp_q.size() > 0) begin
      logic [31:0] e, o; string t;
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_kb_push_pop();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) kb_push(8'h60 + 8'(i));
    expect_val("full_pushpop_data", 32'h60);
    cyc(A_KB_DATA, 1'b1, 1'b0, 32'd0, 1'b1, 8'h68, v); obs_q.push_back(v);
    expect_val("full_pushpop_status", 32'h0000_0802); rd(A_KB_STATUS, 1'b0);
    for (int i = 0; i < 8; i++) begin
      expect_val($sformatf("full_drain%0d", i), 32'h61 + 32'(i));
      rd(A_KB_DATA, 1'b1);
    end
    expect_val("empty_pushpop_data", 32'h0);
    cyc(A_KB_DATA, 1'b1, 1'b0, 32'd0, 1'b1, 8'h70, v); obs_q.push_back(v);
    expect_val("empty_pushpop_status", 32'h0000_0100); rd(A_KB_STATUS, 1'b0);
    expect_val("empty_pushpop_pop", 32'h70); rd(A_KB_DATA, 1'b1);
    kb_push(8'h71); kb_push(8'h72);
    expect_val("rdwr_kbdata", 32'h71);
    cyc(A_KB_DATA, 1'b1, 1'b1, 32'h0000_00EE, 1'b0, 8'd0, v); obs_q.push_back(v);
    expect_val("rdwr_next", 32'h72); rd(A_KB_DATA, 1'b1);
    expect_val("rdwr_status", 32'h0000_0001); rd(A_KB_STATUS, 1'b0);
    while (exp_q.size() > 0) begin
      logic [31:0] e, o; string t;
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_screen();
    scr_rd_addr = 11'd5;
    wr(A_SCR + 32'd20, 32'h0000_003C);
    expect_val("scr_disp5", 32'h0000_000C); obs_q.push_back({28'd0, scr_rd_char});
    expect_val("scr_cpu5", 32'h0000_000C); rd(A_SCR + 32'd20, 1'b0);
    wr(A_SCR + 32'd4796, 32'h0000_0007);
    scr_rd_addr = 11'd1199;
    #1;
    expect_val("scr_disp1199", 32'h0000_0007); obs_q.push_back({28'd0, scr_rd_char});
    wr(A_SCR + 32'd4800, 32'h0000_000F);
    expect_val("scr_cpu1200", 32'h0); rd(A_SCR + 32'd4800, 1'b0);
    expect_val("scr_cpu1199", 32'h0000_0007); rd(A_SCR + 32'd4796, 1'b0);
    expect_val("scr_cpu5_again", 32'h0000_000C); rd(A_SCR + 32'd20, 1'b0);
    while (exp_q.size() > 0) begin
      logic [31:0] e, o; string t;
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_seg_dmem();
    logic [31:0] v;
    wr(32'h0000_000C, 32'hDEAD_BEEF);
    wr(32'h0000_101C, 32'hCAFE_0007);
    expect_val("dmem_wrap", 32'hCAFE_0007); rd(32'h0000_001C, 1'b0);
    wr(A_SEG, 32'h1234_5678);
    expect_val("seg_port", 32'h1234_5678); obs_q.push_back(seg_value);
    expect_val("seg_rd", 32'h1234_5678); rd(A_SEG, 1'b0);
    wr(A_UNMAPPED, 32'hFFFF_FFFF);
    expect_val("unmapped_rd", 32'h0); rd(A_UNMAPPED, 1'b0);
    wr(A_IO_RSVD, 32'hFFFF_FFFF);
    expect_val("io_rsvd_rd", 32'h0); rd(A_IO_RSVD, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cyc(32'h0000_000C, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b1, 8'h33, v);
    @(negedge clk);
    reset = 1'b0;
    expect_val("seg_port_rst", 32'h0); obs_q.push_back(seg_value);
    expect_val("dmem_keep", 32'hDEAD_BEEF); rd(32'h0000_000C, 1'b0);
    expect_val("kb_rst_status", 32'h0000_0001); rd(A_KB_STATUS, 1'b0);
    while (exp_q.size() > 0) begin
      logic [31:0] e, o; string t;
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_timer();
    wr(A_TIMER, 32'hFFFF_FFFE);
    mem_addr = A_TIMER;
`ifdef MMIO_HUB_TIMER_EN
    expect_val("timer_load", 32'hFFFF_FFFE);
    expect_val("timer_plus1", 32'hFFFF_FFFF);
    expect_val("timer_wrap", 32'h0000_0000);
`else
    expect_val("timer_off0", 32'h0);
    expect_val("timer_off1", 32'h0);
    expect_val("timer_off2", 32'h0);
`endif
    #1 obs_q.push_back(mem_readdata);
    @(posedge clk); #1 obs_q.push_back(mem_readdata);
    @(posedge clk); #1 obs_q.push_back(mem_readdata);
    while (exp_q.size() > 0) begin
      logic [31:0] e, o; string t;
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_kb_basic();
    test_kb_overflow();
    test_kb_push_pop();
    test_screen();
    test_seg_dmem();
    test_timer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
